alu_arbiter: RTL

Shares the single combinational 8-bit alu instance between NUM_REQ requesters.
- Arbitrates with a round-robin pointer and registers the winner's opcode and operands.
- Drives the alu from those registers, captures result/set/zero, and returns them to the winner over a valid/ready response channel.
- Sits between the decode/issue logic of multiple pipeline clients and the shared alu datapath.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 39 +++
 rtl/alu_arbiter_rr_pick.sv | 42 ++++
 rtl/alu_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu and the alu_arbiter: widths, opcodes and
// the arbiter state encoding.
package alu_pkg;

    localparam int DATA_W = 8;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] ALU_OP_AND = 3'b000;
    localparam logic [OP_W-1:0] ALU_OP_OR  = 3'b001;
    localparam logic [OP_W-1:0] ALU_OP_ADD = 3'b010;
    localparam logic [OP_W-1:0] ALU_OP_SLT = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/alu.sv
// Shared combinational 8-bit alu. Unknown opcodes yield result 0; set is only
// raised by a signed set-less-than.
module alu
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]   op_i,
    input  logic [DATA_W-1:0] rs_i,
    input  logic [DATA_W-1:0] rt_i,
    output logic [DATA_W-1:0] alu_result_o,
    output logic              set_o,
    output logic              zero_o
);

    logic signed [DATA_W-1:0] rs_s;
    logic signed [DATA_W-1:0] rt_s;
    logic                     lt;

    assign rs_s = rs_i;
    assign rt_s = rt_i;
    assign lt   = rs_s < rt_s;

    always_comb begin
        alu_result_o = '0;
        set_o        = 1'b0;
        case (op_i)
            ALU_OP_AND: alu_result_o = rs_i & rt_i;
            ALU_OP_OR:  alu_result_o = rs_i | rt_i;
            ALU_OP_ADD: alu_result_o = rs_i + rt_i;
            ALU_OP_SLT: begin
                alu_result_o = {{(DATA_W-1){1'b0}}, lt};
                set_o        = lt;
            end
            default:    alu_result_o = '0;
        endcase
    end

    assign zero_o = (alu_result_o == '0);

endmodule

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or above ptr_i,
// wrapping modulo NUM_REQ, as a one-hot grant plus its index.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= 32'(NUM_REQ)) s = s - 32'(NUM_REQ);
        return IDX_W'(s);
    endfunction

    logic [IDX_W-1:0] k;
    logic             found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = wrap_idx(ptr_i, 32'(i));
            if (!found && valid_i[k]) begin
                grant_o[k] = 1'b1;
                idx_o      = k;
                found      = 1'b1;
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between NUM_REQ requesters (IDLE/EXEC/RESP).
// Optional ALU_ARB_OPCOUNT_EN adds op_count_o and stall_o.
module alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 8,
    parameter int OP_W    = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*OP_W-1:0]     req_op_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rs_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_rt_i,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    input  logic [NUM_REQ-1:0]          rsp_ready_i,
    output logic [DATA_W-1:0]           rsp_result_o,
    output logic                        rsp_set_o,
    output logic                        rsp_zero_o
`ifdef ALU_ARB_OPCOUNT_EN
    ,
    output logic [15:0]                 op_count_o,
    output logic [NUM_REQ-1:0]          stall_o
`endif
);

    import alu_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_q;
    logic [OP_W-1:0]    op_q;
    logic [DATA_W-1:0]  rs_q, rt_q;
    logic [DATA_W-1:0]  result_q;
    logic               set_q, zero_q;

    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;
    logic               req_hs, rsp_hs;

    logic [DATA_W-1:0]  alu_result;
    logic               alu_set, alu_zero;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .valid_i (req_valid_i),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (grant_idx),
        .any_o   (grant_any)
    );

    // The alu only ever sees the latched request, never the live request ports.
    alu u_alu (
        .op_i         (op_q),
        .rs_i         (rs_q),
        .rt_i         (rt_q),
        .alu_result_o (alu_result),
        .set_o        (alu_set),
        .zero_o       (alu_zero)
    );

    assign req_hs = (state_q == IDLE) && grant_any;
    assign rsp_hs = (state_q == RESP) && rsp_ready_i[owner_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_any) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready_i[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == IDLE) ? grant : '0;
        rsp_valid_o = '0;
        if (state_q == RESP) rsp_valid_o[owner_q] = 1'b1;
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (rsp_hs) begin
            rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            op_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            result_q <= '0;
            set_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (req_hs) begin
                owner_q <= grant_idx;
                op_q    <= req_op_i[grant_idx*OP_W +: OP_W];
                rs_q    <= req_rs_i[grant_idx*DATA_W +: DATA_W];
                rt_q    <= req_rt_i[grant_idx*DATA_W +: DATA_W];
            end
            if (state_q == EXEC) begin
                result_q <= alu_result;
                set_q    <= alu_set;
                zero_q   <= alu_zero;
            end
        end
    end

    assign rsp_result_o = result_q;
    assign rsp_set_o    = set_q;
    assign rsp_zero_o   = zero_q;

`ifdef ALU_ARB_OPCOUNT_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_count_q <= '0;
        end else if (rsp_hs) begin
            op_count_q <= op_count_q + 16'd1;
        end
    end

    assign op_count_o = op_count_q;
    assign stall_o    = req_valid_i & ~req_ready_o;
`endif

endmodule
